// File: rtl/i2s_pkg.sv
// Shared defaults and the stereo sample type for the I2S transmit path.
package i2s_pkg;
  localparam int I2S_DATA_W   = 24;
  localparam int I2S_SLOT_W   = 32;
  localparam int I2S_BCLK_DIV = 4;

  typedef struct packed {
    logic [I2S_DATA_W-1:0] left;
    logic [I2S_DATA_W-1:0] right;
  } stereo_sample_t;
endpackage

// File: rtl/i2s_bit_timer.sv
// BCLK/LRCLK timebase. The first enabled edge after an idle period is a frame
// start, so every enable rise begins at left slot bit 0.
module i2s_bit_timer
  import i2s_pkg::*;
#(
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV,
  localparam int BIT_W   = $clog2(2*SLOT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic             bclk_o,
  output logic             lrclk_o,
  output logic             bit_fall_o,
  output logic             frame_start_o,
  output logic [BIT_W-1:0] bit_nxt_o
);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV-1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV/2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2*SLOT_W-1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] r_div_cnt, w_div_nxt;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_nxt;
  logic             r_run, r_bclk, r_lrclk, w_wrap;

  assign w_wrap        = ~r_run | (r_div_cnt == DIV_LAST);
  assign bit_fall_o    = en_i & w_wrap;
  assign frame_start_o = en_i & (~r_run | (w_wrap & (r_bit_cnt == BIT_LAST)));
  assign w_div_nxt     = w_wrap ? '0 : r_div_cnt + DIV_W'(1);
  assign w_bit_nxt     = ~r_run ? '0 :
                         ~w_wrap ? r_bit_cnt :
                         (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
  assign bit_nxt_o     = w_bit_nxt;
  assign bclk_o        = r_bclk;
  assign lrclk_o       = r_lrclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
    end else if (!en_i) begin
      r_run     <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_bclk    <= (w_div_nxt >= DIV_HALF);
      r_lrclk   <= (w_bit_nxt >= BIT_HALF);
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: double-buffered stereo samples serialised MSB first with a
// one-BCLK delay. Define I2S_TX_HOLD_LAST_EN to repeat the last frame on underrun.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W   = I2S_DATA_W,
  parameter int SLOT_W   = I2S_SLOT_W,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_left_i,
  input  logic [DATA_W-1:0] s_right_i,
  output logic              bclk_o,
  output logic              lrclk_o,
  output logic              sdata_o,
  output logic              frame_o,
  output logic              underrun_o
);
  localparam int BIT_W = $clog2(2*SLOT_W);

  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } sample_t;

  sample_t          r_pend, r_active;
  logic             r_pend_full, r_ready, r_armed, r_sdata, r_frame, r_underrun;
  logic             w_en, w_xfer, w_bit_fall, w_frame_start, w_sdata_nxt;
  logic [BIT_W-1:0] w_bit_nxt;
  logic [DATA_W-1:0] w_word, w_shift;
  int               w_slot, w_k;

  // Hold the timebase idle for the first edge out of reset so ready rises first.
  assign w_en   = en_i & r_armed;
  assign w_xfer = s_valid_i & r_ready;

  i2s_bit_timer #(.SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (w_en),
    .bclk_o       (bclk_o),
    .lrclk_o      (lrclk_o),
    .bit_fall_o   (w_bit_fall),
    .frame_start_o(w_frame_start),
    .bit_nxt_o    (w_bit_nxt)
  );

  always_comb begin
    w_slot      = int'(w_bit_nxt) % SLOT_W;
    w_k         = w_slot - 1;
    w_word      = (int'(w_bit_nxt) < SLOT_W) ? r_active.left : r_active.right;
    w_shift     = '0;
    w_sdata_nxt = 1'b0;
    if (w_k >= 0 && w_k < DATA_W) begin
      w_shift     = w_word << w_k;
      w_sdata_nxt = w_shift[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b0;
      r_ready     <= 1'b0;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_active    <= '0;
      r_sdata     <= 1'b0;
      r_frame     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_frame    <= w_frame_start;
      r_underrun <= w_frame_start & ~r_pend_full;
      if (w_xfer) r_pend <= '{left: s_left_i, right: s_right_i};
      r_pend_full <= w_xfer | (r_pend_full & ~w_frame_start);
      // Stays low for the consuming edge; reasserts one edge later.
      r_ready     <= ~(w_xfer | r_pend_full);

      if (!w_en) begin
        r_active <= '0;
      end else if (w_frame_start) begin
        if (r_pend_full) r_active <= r_pend;
`ifdef I2S_TX_HOLD_LAST_EN
        else r_active <= r_active;
`else
        else r_active <= '0;
`endif
      end

      if (!w_en)           r_sdata <= 1'b0;
      else if (w_bit_fall) r_sdata <= w_sdata_nxt;
    end
  end

  assign s_ready_o  = r_ready;
  assign sdata_o    = r_sdata;
  assign frame_o    = r_frame;
  assign underrun_o = r_underrun;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: frame-time arithmetic reference model plus
// directed steps, a decoded-frame check and a randomized tail.
module tb_i2s_tx;
  localparam int DW    = 24;
  localparam int SLOT  = 32;
  localparam int DIV   = 4;
  localparam int FRAME = 2*SLOT*DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b1;
  logic          s_valid_i = 1'b0;
  logic [DW-1:0] s_left_i = '0;
  logic [DW-1:0] s_right_i = '0;
  logic          s_ready_o, bclk_o, lrclk_o, sdata_o, frame_o, underrun_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: position in frame, buffers, handshake.
  int          m_t = 0;
  bit          m_run = 0, m_armed = 0, m_ready = 0, m_pend_v = 0, m_xfer = 0;
  logic [DW-1:0] m_pl = '0, m_pr = '0, m_al = '0, m_ar = '0;
  int          n_acc = 0;

  i2s_tx dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .s_left_i(s_left_i), .s_right_i(s_right_i),
    .bclk_o(bclk_o), .lrclk_o(lrclk_o), .sdata_o(sdata_o),
    .frame_o(frame_o), .underrun_o(underrun_o)
  );

  always #5 clk = ~clk;

  function automatic logic slot_bit(input logic [DW-1:0] w, input int k);
    logic [DW-1:0] s;
    if (k < 0 || k >= DW) return 1'b0;
    s = w << k;
    return s[DW-1];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_run = 0; m_armed = 0; m_ready = 0; m_pend_v = 0;
    m_pl = '0; m_pr = '0; m_al = '0; m_ar = '0;
  endtask

  // Advance model and DUT by one clock and compare all outputs.
  task automatic step(input string tag);
    bit live, bnd, fr, ur, consumed, e_bclk, e_lr, e_sd;
    int bp;
    live = en_i && m_armed;
    m_xfer = s_valid_i && m_ready;
    bnd = 0; fr = 0; ur = 0; consumed = 0;
    if (!live) begin
      m_run = 0; m_t = 0; m_al = '0; m_ar = '0;
    end else if (!m_run) begin
      m_run = 1; m_t = 0; bnd = 1;
    end else begin
      m_t = (m_t + 1) % FRAME;
      bnd = (m_t == 0);
    end
    if (bnd) begin
      fr = 1;
      if (m_pend_v) begin
        m_al = m_pl; m_ar = m_pr; m_pend_v = 0; consumed = 1;
      end else begin
        ur = 1;
`ifdef I2S_TX_HOLD_LAST_EN
        m_al = m_al; m_ar = m_ar;
`else
        m_al = '0; m_ar = '0;
`endif
      end
    end
    if (m_xfer) begin
      m_pl = s_left_i; m_pr = s_right_i; m_pend_v = 1; n_acc++;
    end
    m_ready = !m_pend_v && !consumed;
    m_armed = 1;
    bp     = m_t / DIV;
    e_bclk = live && ((m_t % DIV) >= DIV/2);
    e_lr   = live && (bp >= SLOT);
    e_sd   = live && slot_bit((bp < SLOT) ? m_al : m_ar, (bp % SLOT) - 1);
    @(posedge clk); #1;
    chk(tag, {26'd0, s_ready_o, bclk_o, lrclk_o, sdata_o, frame_o, underrun_o},
             {26'd0, m_ready, e_bclk, e_lr, e_sd, fr, ur});
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic send(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit done = 0;
    s_valid_i = 1'b1; s_left_i = l; s_right_i = r;
    for (int i = 0; i < 600 && !done; i++) begin
      step(tag);
      done = m_xfer;
    end
    s_valid_i = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout observed=no_accept expected=accept", tag);
    end
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(tag);
      seen = frame_o;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout observed=no_frame expected=frame", tag);
    end
  endtask

  task automatic step_to(input string tag, input int t);
    for (int i = 0; i < 300 && !(m_run && m_t == t); i++) step(tag);
    chk({tag, "_pos"}, m_t, t);
  endtask

  initial begin
    logic [63:0]   cap;
    logic [DW-1:0] dl, dr, pat;
    int            nur, acc0;

    // Reset with enable already high
    @(posedge clk); @(posedge clk); #1;
    chk("reset_idle", {26'd0, s_ready_o, bclk_o, lrclk_o, sdata_o, frame_o, underrun_o}, 32'd0);
    model_reset();
    rst_n = 1'b1;
    step("release_ready");
    step("release_frame");

    // Basic frame, decoded independently of the model
    send("basic_send", 24'hA5F00F, 24'h5A0FF0);
    wait_frame("basic_wait");
    cap = '0;
    for (int i = 1; i < FRAME; i++) begin
      step("basic_frame");
      if (m_t % DIV == DIV/2) cap[m_t/DIV] = sdata_o;
    end
    for (int p = 1; p <= DW; p++) begin
      dl[DW-p] = cap[p];
      dr[DW-p] = cap[SLOT+p];
    end
    chk("basic_left", {8'd0, dl}, 32'h00A5F00F);
    chk("basic_right", {8'd0, dr}, 32'h005A0FF0);
    chk("basic_pad_bits", {cap[63:57], cap[32], cap[31:25], cap[0]}, 32'd0);
    step("basic_period");
    chk("basic_period_frame", {31'd0, frame_o}, 32'd1);

    // Back-pressure: valid held high with an incrementing pattern
    pat = 24'h000001; nur = 0; acc0 = n_acc;
    s_valid_i = 1'b1;
    for (int i = 0; i < 6*FRAME; i++) begin
      s_left_i = pat; s_right_i = ~pat;
      step("bp");
      if (m_xfer) pat = pat + 24'd1;
      if (underrun_o) nur++;
    end
    s_valid_i = 1'b0;
    chk("bp_underruns", nur, 0);
    chk("bp_accepts", n_acc - acc0, 6);

    // Underrun after a last sample
    send("ur_send", 24'h000123, 24'h000123);
    wait_frame("ur_load");
    wait_frame("ur_wait");
    chk("ur_pulse", {31'd0, underrun_o}, 32'd1);
    steps("ur_frame", FRAME);

    // Sample arrives exactly on a boundary edge with pend empty
    step_to("race", FRAME-1);
    s_valid_i = 1'b1; s_left_i = DW'($urandom); s_right_i = DW'($urandom);
    step("race_edge");
    s_valid_i = 1'b0;
    chk("race_underrun", {30'd0, frame_o, underrun_o}, 32'd3);
    steps("race_next", FRAME + 8);

    // Mid-frame disable at bit 40, then re-enable
    send("dis_send", DW'($urandom), DW'($urandom));
    wait_frame("dis_wait");
    step_to("dis", 40*DIV);
    en_i = 1'b0;
    step("dis_edge");
    chk("dis_quiet", {27'd0, bclk_o, lrclk_o, sdata_o, frame_o, underrun_o}, 32'd0);
    steps("dis_idle", 5);
    en_i = 1'b1;
    step("reen_edge");
    chk("reen_frame", {31'd0, frame_o}, 32'd1);
    steps("reen_run", FRAME);

    // Mid-frame async reset
    step_to("rst", 40*DIV);
    rst_n = 1'b0; #1;
    chk("rst_async", {26'd0, s_ready_o, bclk_o, lrclk_o, sdata_o, frame_o, underrun_o}, 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    steps("rst_recover", 4);

    // Randomized tail: sparse enable drops, random valid and data
    for (int i = 0; i < 3000; i++) begin
      en_i      = ($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0;
      s_valid_i = $urandom_range(0, 3) == 0;
      s_left_i  = DW'($urandom);
      s_right_i = DW'($urandom);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
